// File: rtl/ram_gather_pkg.sv
// Shared size codes and byte-count mapping for the mcpu load/store byte engines.
// Both the store serializer and the load gatherer use these codes.
package ram_gather_pkg;

    localparam int MAX_BYTES = 8;
    localparam int RES_W     = 8 * MAX_BYTES;

    typedef enum logic [1:0] {
        SZ_NONE  = 2'b00,
        SZ_BYTE  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    function automatic logic [3:0] byte_count(input size_e sz);
        case (sz)
            SZ_BYTE:  return 4'd1;
            SZ_WORD:  return 4'd4;
            SZ_DWORD: return 4'd8;
            default:  return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ram_gather_if.sv
// Load-path bundle: request/result handshake plus the byte-wide RAM read port.
// The master side is the load requester together with the data RAM.
interface ram_gather_if #(
    parameter int AW = 16,
    parameter int DW = 64
);
    logic          start;
    logic [1:0]    size;
    logic          sext;
    logic [AW-1:0] addr;
    logic [7:0]    ram_q;
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic          busy;
    logic [DW-1:0] q;
    logic          done;

    modport master (
        output start, size, sext, addr, ram_q,
        input  ram_addr, ram_re, busy, q, done
    );

    modport slave (
        input  start, size, sext, addr, ram_q,
        output ram_addr, ram_re, busy, q, done
    );
endinterface

// File: rtl/ram_gather_load_ext.sv
// Width/sign extender: turns the little-endian byte accumulator into the final
// load result for the latched access size.
module load_ext
    import ram_gather_pkg::*;
(
    input  logic [RES_W-1:0] acc,
    input  size_e            size,
    input  logic             sext,
    output logic [RES_W-1:0] res
);
    logic fill_b;
    logic fill_w;

    assign fill_b = sext & acc[7];
    assign fill_w = sext & acc[31];

    always_comb begin
        res = '0;
        case (size)
            SZ_BYTE:  res = {{56{fill_b}}, acc[7:0]};
            SZ_WORD:  res = {{32{fill_w}}, acc[31:0]};
            SZ_DWORD: res = acc;
            default:  res = '0;
        endcase
    end
endmodule

// File: rtl/ram_gather.sv
// Byte-serial load gatherer: streams 1/4/8 consecutive bytes out of the
// synchronous data RAM and assembles them little-endian into a 64-bit result.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; busy low
// ST_FETCH | issuing addresses and capturing returned bytes; busy high
// ST_DONE  | one-cycle done pulse; start ignored
module ram_gather
    import ram_gather_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_gather_if.slave  bus
);
    state_e        state_r,    state_nx;
    logic [AW-1:0] ram_addr_r, ram_addr_nx;
    logic          ram_re_r,   ram_re_nx;
    logic          busy_r,     busy_nx;
    logic [DW-1:0] q_r,        q_nx;
    logic          done_r,     done_nx;
    size_e         sz_r,       sz_nx;
    logic          sext_r,     sext_nx;
    logic [3:0]    n_bytes_r,  n_bytes_nx;
    logic [3:0]    issue_r,    issue_nx;
    logic [2:0]    cap_idx_r,  cap_idx_nx;
    logic          rd_vld_r,   rd_vld_nx;
    logic [DW-1:0] acc_r,      acc_nx;

    logic [DW-1:0] acc_merged;
    logic [DW-1:0] ext_res;
    logic          last_cap;

    // Accumulator is cleared at start, so OR-merging the incoming byte is exact.
    assign acc_merged = acc_r | (DW'(bus.ram_q) << {cap_idx_r, 3'b000});
    assign last_cap   = ({1'b0, cap_idx_r} == (n_bytes_r - 4'd1));

    load_ext u_ext (
        .acc  (acc_merged),
        .size (sz_r),
        .sext (sext_r),
        .res  (ext_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ram_addr_r <= '0;
            ram_re_r   <= 1'b0;
            busy_r     <= 1'b0;
            q_r        <= '0;
            done_r     <= 1'b0;
            sz_r       <= SZ_NONE;
            sext_r     <= 1'b0;
            n_bytes_r  <= '0;
            issue_r    <= '0;
            cap_idx_r  <= '0;
            rd_vld_r   <= 1'b0;
            acc_r      <= '0;
        end else begin
            state_r    <= state_nx;
            ram_addr_r <= ram_addr_nx;
            ram_re_r   <= ram_re_nx;
            busy_r     <= busy_nx;
            q_r        <= q_nx;
            done_r     <= done_nx;
            sz_r       <= sz_nx;
            sext_r     <= sext_nx;
            n_bytes_r  <= n_bytes_nx;
            issue_r    <= issue_nx;
            cap_idx_r  <= cap_idx_nx;
            rd_vld_r   <= rd_vld_nx;
            acc_r      <= acc_nx;
        end
    end

    always_comb begin
        state_nx    = state_r;
        ram_addr_nx = ram_addr_r;
        ram_re_nx   = ram_re_r;
        busy_nx     = busy_r;
        q_nx        = q_r;
        done_nx     = 1'b0;
        sz_nx       = sz_r;
        sext_nx     = sext_r;
        n_bytes_nx  = n_bytes_r;
        issue_nx    = issue_r;
        cap_idx_nx  = cap_idx_r;
        rd_vld_nx   = 1'b0;
        acc_nx      = acc_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (size_e'(bus.size) != SZ_NONE) begin
                        sz_nx       = size_e'(bus.size);
                        n_bytes_nx  = byte_count(size_e'(bus.size));
                        sext_nx     = bus.sext;
                        ram_addr_nx = bus.addr;
                        ram_re_nx   = 1'b1;
                        busy_nx     = 1'b1;
                        issue_nx    = 4'd1;
                        cap_idx_nx  = '0;
                        acc_nx      = '0;
                        state_nx    = ST_FETCH;
                    end else begin
                        q_nx     = '0;
                        done_nx  = 1'b1;
                        state_nx = ST_DONE;
                    end
                end
            end

            ST_FETCH: begin
                // ram_re seen by the RAM this edge means a byte arrives next cycle.
                rd_vld_nx = ram_re_r;
                if (issue_r < n_bytes_r) begin
                    ram_addr_nx = ram_addr_r + AW'(1);
                    issue_nx    = issue_r + 4'd1;
                end else begin
                    ram_re_nx = 1'b0;
                end

                if (rd_vld_r) begin
                    acc_nx     = acc_merged;
                    cap_idx_nx = cap_idx_r + 3'd1;
                    if (last_cap) begin
                        q_nx      = ext_res;
                        busy_nx   = 1'b0;
                        done_nx   = 1'b1;
                        ram_re_nx = 1'b0;
                        rd_vld_nx = 1'b0;
                        state_nx  = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign bus.ram_addr = ram_addr_r;
    assign bus.ram_re   = ram_re_r;
    assign bus.busy     = busy_r;
    assign bus.q        = q_r;
    assign bus.done     = done_r;
endmodule
